// File: rtl/regfile_access_ctrl.sv
// Single-port register file sequencer/arbiter: splits pair accesses into two bytes.
// Define REGFILE_CTRL_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module regfile_access_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req0_valid,
    output logic                      o_req0_ready,
    input  logic                      i_req0_wr,
    input  logic                      i_req0_pair,
    input  logic [ADDRESS_WIDTH-1:0]  i_req0_addr,
    input  logic [2*DATA_WIDTH-1:0]   i_req0_data,
    input  logic                      i_req1_valid,
    output logic                      o_req1_ready,
    input  logic                      i_req1_wr,
    input  logic                      i_req1_pair,
    input  logic [ADDRESS_WIDTH-1:0]  i_req1_addr,
    input  logic [2*DATA_WIDTH-1:0]   i_req1_data,
    output logic                      o_rsp_valid,
    output logic                      o_rsp_id,
    output logic                      o_rsp_err,
    output logic [2*DATA_WIDTH-1:0]   o_rsp_data,
    output logic                      o_rf_wr_en,
    output logic                      o_rf_rd_en,
    output logic [ADDRESS_WIDTH-1:0]  o_rf_addr,
    output logic [DATA_WIDTH-1:0]     o_rf_data,
    input  logic [DATA_WIDTH-1:0]     i_rf_data
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [AW-1:0] MEM_CODE = AW'(6);

    typedef enum logic [2:0] {
        IDLE,
        BYTE0,
        BYTE1,
        CAP,
        RSP
    } state_t;

    state_t state;

    logic          lat_wr;
    logic          lat_pair;
    logic [AW-2:0] lat_pair_sel;
    logic [DW-1:0] lat_lo;

    logic          grant0;
    logic          grant1;
    logic          is_idle;
    logic          accept;

    logic            sel_wr;
    logic            sel_pair;
    logic [AW-1:0]   sel_addr;
    logic [2*DW-1:0] sel_data;
    logic            sel_illegal;

`ifdef REGFILE_CTRL_FIXED_PRIO_EN
    assign grant0 = i_req0_valid;
    assign grant1 = i_req1_valid & ~i_req0_valid;
`else
    // last_grant = 1 means requester 1 won the previous arbitration
    logic last_grant;

    assign grant0 = i_req0_valid & (~i_req1_valid | last_grant);
    assign grant1 = i_req1_valid & (~i_req0_valid | ~last_grant);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end
`endif

    assign is_idle      = (state == IDLE) & i_reset;
    assign o_req0_ready = is_idle & grant0;
    assign o_req1_ready = is_idle & grant1;
    assign accept       = is_idle & (grant0 | grant1);

    assign sel_wr   = grant1 ? i_req1_wr   : i_req0_wr;
    assign sel_pair = grant1 ? i_req1_pair : i_req0_pair;
    assign sel_addr = grant1 ? i_req1_addr : i_req0_addr;
    assign sel_data = grant1 ? i_req1_data : i_req0_data;

    assign sel_illegal = sel_pair ? (&sel_addr[AW-1:1])
                                  : (sel_addr == MEM_CODE);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= IDLE;
            lat_wr       <= 1'b0;
            lat_pair     <= 1'b0;
            lat_pair_sel <= '0;
            lat_lo       <= '0;
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= 1'b0;
            o_rsp_err    <= 1'b0;
            o_rsp_data   <= '0;
            o_rf_wr_en   <= 1'b0;
            o_rf_rd_en   <= 1'b0;
            o_rf_addr    <= '0;
            o_rf_data    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        lat_wr       <= sel_wr;
                        lat_pair     <= sel_pair;
                        lat_pair_sel <= sel_addr[AW-1:1];
                        lat_lo       <= sel_data[DW-1:0];
                        o_rsp_id     <= grant1;
                        o_rsp_err    <= sel_illegal;
                        o_rsp_data   <= '0;
                        if (sel_illegal) begin
                            state       <= RSP;
                            o_rsp_valid <= 1'b1;
                        end else begin
                            // Strobes are registered: set up BYTE0 here
                            state      <= BYTE0;
                            o_rf_wr_en <= sel_wr;
                            o_rf_rd_en <= ~sel_wr;
                            o_rf_addr  <= sel_pair ? {sel_addr[AW-1:1], 1'b0}
                                                   : sel_addr;
                            o_rf_data  <= sel_wr ? (sel_pair ? sel_data[2*DW-1:DW]
                                                             : sel_data[DW-1:0])
                                                 : '0;
                        end
                    end
                end
                BYTE0: begin
                    if (lat_pair) begin
                        state      <= BYTE1;
                        o_rf_wr_en <= lat_wr;
                        o_rf_rd_en <= ~lat_wr;
                        o_rf_addr  <= {lat_pair_sel, 1'b1};
                        o_rf_data  <= lat_wr ? lat_lo : '0;
                    end else begin
                        o_rf_wr_en <= 1'b0;
                        o_rf_rd_en <= 1'b0;
                        o_rf_addr  <= '0;
                        o_rf_data  <= '0;
                        if (lat_wr) begin
                            state       <= RSP;
                            o_rsp_valid <= 1'b1;
                        end else begin
                            state <= CAP;
                        end
                    end
                end
                BYTE1: begin
                    o_rf_wr_en <= 1'b0;
                    o_rf_rd_en <= 1'b0;
                    o_rf_addr  <= '0;
                    o_rf_data  <= '0;
                    if (lat_wr) begin
                        state       <= RSP;
                        o_rsp_valid <= 1'b1;
                    end else begin
                        state                   <= CAP;
                        o_rsp_data[2*DW-1:DW]   <= i_rf_data;
                    end
                end
                CAP: begin
                    state             <= RSP;
                    o_rsp_valid       <= 1'b1;
                    o_rsp_data[DW-1:0] <= i_rf_data;
                end
                RSP: begin
                    state       <= IDLE;
                    o_rsp_valid <= 1'b0;
                end
                default: begin
                    state       <= IDLE;
                    o_rsp_valid <= 1'b0;
                    o_rf_wr_en  <= 1'b0;
                    o_rf_rd_en  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural register file.
// Stimulus pushes expected strobes/responses; monitors pop and compare.
module tb_regfile_access_ctrl;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        r0_valid, r0_wr, r0_pair;
    logic [2:0]  r0_addr;
    logic [15:0] r0_data;
    logic        r1_valid, r1_wr, r1_pair;
    logic [2:0]  r1_addr;
    logic [15:0] r1_data;
    logic        o_req0_ready, o_req1_ready;
    logic        o_rsp_valid, o_rsp_id, o_rsp_err;
    logic [15:0] o_rsp_data;
    logic        o_rf_wr_en, o_rf_rd_en;
    logic [2:0]  o_rf_addr;
    logic [7:0]  o_rf_data;
    logic [7:0]  rf_rdata;

    regfile_access_ctrl #(.DATA_WIDTH(8), .ADDRESS_WIDTH(3)) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_req0_valid (r0_valid),
        .o_req0_ready (o_req0_ready),
        .i_req0_wr    (r0_wr),
        .i_req0_pair  (r0_pair),
        .i_req0_addr  (r0_addr),
        .i_req0_data  (r0_data),
        .i_req1_valid (r1_valid),
        .o_req1_ready (o_req1_ready),
        .i_req1_wr    (r1_wr),
        .i_req1_pair  (r1_pair),
        .i_req1_addr  (r1_addr),
        .i_req1_data  (r1_data),
        .o_rsp_valid  (o_rsp_valid),
        .o_rsp_id     (o_rsp_id),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_data   (o_rsp_data),
        .o_rf_wr_en   (o_rf_wr_en),
        .o_rf_rd_en   (o_rf_rd_en),
        .o_rf_addr    (o_rf_addr),
        .o_rf_data    (o_rf_data),
        .i_rf_data    (rf_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file model with a 1-cycle registered read
    logic [7:0] regs [8];
    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        rf_rdata = 8'h00;
    end
    always @(posedge clk) begin
        if (o_rf_wr_en) regs[o_rf_addr] <= o_rf_data;
        if (o_rf_rd_en) rf_rdata <= regs[o_rf_addr];
    end

    typedef struct {
        logic       wr;
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;
    } strb_t;

    typedef struct {
        logic        id;
        logic        err;
        logic [15:0] data;
        int          cyc;
    } rsp_t;

    strb_t sq[$];
    rsp_t  rq[$];
    int n_checks = 0;
    int n_pass = 0;
    int last_rsp_cyc = -100;

    function automatic void chk(input string nm, input logic [31:0] got,
                                input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                      nm, got, exp, cyc);
    endfunction

    always @(negedge clk) begin
        if (i_reset && (o_rf_wr_en || o_rf_rd_en)) begin
            strb_t e;
            chk("strobe_exclusive", 32'(o_rf_wr_en & o_rf_rd_en), 32'd0);
            if (sq.size() == 0) begin
                chk("unexpected_strobe", 32'(o_rf_addr), 32'hDEAD);
            end else begin
                e = sq.pop_front();
                chk("strobe_kind", 32'(o_rf_wr_en), 32'(e.wr));
                chk("strobe_addr", 32'(o_rf_addr), 32'(e.addr));
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
                if (e.wr) chk("strobe_data", 32'(o_rf_data), 32'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        if (i_reset && o_rsp_valid) begin
            rsp_t e;
            last_rsp_cyc = cyc;
            if (rq.size() == 0) begin
                chk("unexpected_rsp", 32'(o_rsp_id), 32'hDEAD);
            end else begin
                e = rq.pop_front();
                chk("rsp_id", 32'(o_rsp_id), 32'(e.id));
                chk("rsp_err", 32'(o_rsp_err), 32'(e.err));
                chk("rsp_data", 32'(o_rsp_data), 32'(e.data));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic exp_strb(input logic wr, input logic [2:0] addr,
                            input logic [7:0] data, input int c);
        strb_t s;
        s.wr = wr; s.addr = addr; s.data = data; s.cyc = c;
        sq.push_back(s);
    endtask

    task automatic issue(input logic id, input logic wr, input logic pair,
                         input logic [2:0] addr, input logic [15:0] data,
                         input logic err, input logic [15:0] rdata,
                         input int lat, input bit want_rsp, output int acc);
        logic got;
        rsp_t r;
        if (!id) begin
            r0_wr = wr; r0_pair = pair; r0_addr = addr; r0_data = data;
            r0_valid = 1'b1;
        end else begin
            r1_wr = wr; r1_pair = pair; r1_addr = addr; r1_data = data;
            r1_valid = 1'b1;
        end
        got = 1'b0;
        acc = -1;
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            got = id ? o_req1_ready : o_req0_ready;
        end
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            acc = cyc;
            if (want_rsp) begin
                r.id = id; r.err = err; r.data = rdata; r.cyc = acc + lat;
                rq.push_back(r);
            end
        end
        @(posedge clk);
        #1;
        // Scramble the request after acceptance; it must be ignored
        r0_valid = 1'b0; r1_valid = 1'b0;
        r0_data = 16'hFFFF; r1_data = 16'hFFFF;
        r0_addr = 3'd7; r1_addr = 3'd7;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || sq.size() != 0) && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (n >= 60) chk("drain_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_grant(input int g);
`ifdef REGFILE_CTRL_FIXED_PRIO_EN
        return 1'b0;
`else
        return (g % 2) == 1;
`endif
    endfunction

    int acc;

    initial begin
        i_reset = 1'b0;
        r0_valid = 1'b1; r0_wr = 1'b0; r0_pair = 1'b0;
        r0_addr = 3'd0; r0_data = 16'h0;
        r1_valid = 1'b1; r1_wr = 1'b0; r1_pair = 1'b0;
        r1_addr = 3'd1; r1_data = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready0", 32'(o_req0_ready), 32'd0);
        chk("reset_ready1", 32'(o_req1_ready), 32'd0);
        chk("reset_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("reset_rsp_data", 32'(o_rsp_data), 32'd0);
        chk("reset_strobes", 32'({o_rf_wr_en, o_rf_rd_en}), 32'd0);
        chk("reset_rf_addr", 32'(o_rf_addr), 32'd0);
        r0_valid = 1'b0; r1_valid = 1'b0;
        i_reset = 1'b1;
        @(posedge clk);
        #1;

        // byte write E=0x5A, then read it back
        issue(1'b0, 1'b1, 1'b0, 3'd3, 16'h005A, 1'b0, 16'h0000, 2, 1, acc);
        exp_strb(1'b1, 3'd3, 8'h5A, acc + 1);
        issue(1'b0, 1'b0, 1'b0, 3'd3, 16'h0000, 1'b0, 16'h005A, 3, 1, acc);
        exp_strb(1'b0, 3'd3, 8'h00, acc + 1);

        // pair write HL=0xBEEF, pair read via addr 5
        issue(1'b1, 1'b1, 1'b1, 3'd4, 16'hBEEF, 1'b0, 16'h0000, 3, 1, acc);
        exp_strb(1'b1, 3'd4, 8'hBE, acc + 1);
        exp_strb(1'b1, 3'd5, 8'hEF, acc + 2);
        issue(1'b1, 1'b0, 1'b1, 3'd5, 16'h0000, 1'b0, 16'hBEEF, 4, 1, acc);
        exp_strb(1'b0, 3'd4, 8'h00, acc + 1);
        exp_strb(1'b0, 3'd5, 8'h00, acc + 2);

        // illegal requests: no strobes, 1-cycle error response
        issue(1'b0, 1'b0, 1'b1, 3'd6, 16'h0000, 1'b1, 16'h0000, 1, 1, acc);
        issue(1'b1, 1'b0, 1'b0, 3'd6, 16'h0000, 1'b1, 16'h0000, 1, 1, acc);
        issue(1'b0, 1'b1, 1'b1, 3'd7, 16'hA5A5, 1'b1, 16'h0000, 1, 1, acc);

        // C=0x77, then abort a BC=0x1234 pair write during BYTE1
        issue(1'b0, 1'b1, 1'b0, 3'd1, 16'h0077, 1'b0, 16'h0000, 2, 1, acc);
        exp_strb(1'b1, 3'd1, 8'h77, acc + 1);
        drain();
        issue(1'b0, 1'b1, 1'b1, 3'd0, 16'h1234, 1'b0, 16'h0000, 0, 0, acc);
        exp_strb(1'b1, 3'd0, 8'h12, acc + 1);
        @(posedge clk);
        #1;
        i_reset = 1'b0;
        #1;
        chk("abort_wr_en", 32'(o_rf_wr_en), 32'd0);
        chk("abort_rf_addr", 32'(o_rf_addr), 32'd0);
        chk("abort_rf_data", 32'(o_rf_data), 32'd0);
        chk("abort_rsp_valid", 32'(o_rsp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        @(posedge clk);
        #1;

        // contention straight after reset, both valids held
        r0_wr = 1'b0; r0_pair = 1'b0; r0_addr = 3'd3; r0_data = 16'h0;
        r1_wr = 1'b0; r1_pair = 1'b0; r1_addr = 3'd5; r1_data = 16'h0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        begin
            int g = 0;
            for (int n = 0; n < 200 && g < 4; n++) begin
                @(negedge clk);
                if (o_req0_ready || o_req1_ready) begin
                    rsp_t r;
                    chk("ready_onehot", 32'(o_req0_ready & o_req1_ready), 32'd0);
                    chk("grant_order", 32'(o_req1_ready), 32'(exp_grant(g)));
                    if (g > 0) chk("b2b_accept", 32'(cyc), 32'(last_rsp_cyc + 1));
                    r.id = o_req1_ready;
                    r.err = 1'b0;
                    r.data = o_req1_ready ? 16'h00EF : 16'h005A;
                    r.cyc = cyc + 3;
                    rq.push_back(r);
                    exp_strb(1'b0, o_req1_ready ? 3'd5 : 3'd3, 8'h00, cyc + 1);
                    g++;
                end
            end
            if (g < 4) chk("contention_timeout", 32'(g), 32'd4);
        end
        @(posedge clk);
        #1;
        r0_valid = 1'b0; r1_valid = 1'b0;
        drain();

        // B holds the aborted high byte, C keeps its old value
        issue(1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0012, 3, 1, acc);
        exp_strb(1'b0, 3'd0, 8'h00, acc + 1);
        issue(1'b0, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 16'h0077, 3, 1, acc);
        exp_strb(1'b0, 3'd1, 8'h00, acc + 1);
        drain();

        chk("rsp_queue_empty", 32'(rq.size()), 32'd0);
        chk("strobe_queue_empty", 32'(sq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Sequencer and arbiter in front of the GB80 8-bit register file. The register file has a single port and a 1-cycle registered read.
- Two requesters share the file:
  - requester 0: core execute/writeback
  - requester 1: load/store unit
- Each request is an 8-bit access or a 16-bit pair access (BC/DE/HL). The block turns a pair access into two byte accesses, issued back to back.
- One transaction is in flight at a time. Each transaction ends with a single-cycle response pulse.

Parameters:
- DATA_WIDTH, 8, byte width of one register.
- ADDRESS_WIDTH, 3, register code width (B=0, C=1, D=2, E=3, H=4, L=5, MEM=6, A=7).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_req0_valid / i_req1_valid  in  1  request pending.
- o_req0_ready / o_req1_ready  out  1  request accepted this cycle.
- i_req0_wr / i_req1_wr  in  1  1 = write, 0 = read.
- i_req0_pair / i_req1_pair  in  1  1 = 16-bit pair access.
- i_req0_addr / i_req1_addr  in  ADDRESS_WIDTH  register code. For pair access, addr[2:1] selects the pair and addr[0] is ignored.
- i_req0_data / i_req1_data  in  2*DATA_WIDTH  write data. A byte write uses [7:0]; a pair write uses {high, low}.
- o_rsp_valid  out  1  one-cycle completion pulse.
- o_rsp_id  out  1  requester that owns the response.
- o_rsp_err  out  1  illegal request.
- o_rsp_data  out  2*DATA_WIDTH  read data; zero for writes and errors.
- o_rf_wr_en / o_rf_rd_en  out  1  register file strobes.
- o_rf_addr  out  ADDRESS_WIDTH  register file address.
- o_rf_data  out  DATA_WIDTH  register file write data.
- i_rf_data  in  DATA_WIDTH  register file read data. It is valid in the cycle after o_rf_rd_en.

Behaviour:
- Reset (i_reset = 0, asynchronous):
  - state returns to IDLE;
  - all outputs are 0;
  - the last-grant flag is set to 1, so requester 0 wins the first contention.
  - Reset during a transaction aborts it with no response. A pair write aborted after its first byte leaves that byte written.
- States: IDLE, BYTE0, BYTE1, CAP, RSP.
- IDLE and arbitration:
  - ready is combinational and asserted only in IDLE, to the granted requester.
  - If exactly one valid is high, that requester is granted.
  - If both are high, the requester not granted last time is granted (round-robin).
  - On valid & ready, the request (wr, pair, addr, data, id) is latched and the last-grant flag is updated.
- Illegal request: a pair access with addr[2:1]=2'b11, or a byte access to addr 6 (MEM).
  - IDLE goes directly to RSP with o_rsp_err=1.
  - No register file strobe is issued.
- Pair address mapping: high byte goes to {addr[2:1],0} and low byte to {addr[2:1],1}. The high byte is always accessed first.
- BYTE0: drive the strobe for the byte address (single access) or the high address (pair).
  - Write data is data[7:0] for a single access and data[15:8] for a pair.
  - Next state: BYTE1 if pair; else CAP if read; else RSP.
- BYTE1: drive the strobe for the low address. Write data is data[7:0].
  - For a pair read, capture i_rf_data into rsp_data[15:8].
  - Next state: CAP if read, else RSP.
- CAP: no strobe. Capture i_rf_data into rsp_data[7:0]. A single-byte read leaves [15:8]=0. Next state: RSP.
- RSP: o_rsp_valid=1 for exactly one cycle, with id, err and data held. Next state: IDLE.
  - There is no response backpressure.
  - A new request can be accepted in the IDLE cycle that follows RSP.
- Strobes: exactly one of o_rf_wr_en / o_rf_rd_en is high in BYTE0 and BYTE1; both are 0 in all other states.
- Latency from the accept cycle to the o_rsp_valid cycle:
  - byte write: 2 cycles
  - byte read: 3 cycles
  - pair write: 3 cycles
  - pair read: 4 cycles
  - error: 1 cycle
- A requester that drops valid without being accepted is not tracked.
- Inputs are sampled only at acceptance. Changes to a requester's inputs after acceptance have no effect.

Optional Feature:
- Macro: REGFILE_CTRL_FIXED_PRIO_EN.
- When defined: fixed priority, requester 0 always wins contention, and the last-grant flag is not implemented.
- When undefined: round-robin as described above.

Test Plan:
- Byte write then read: req0 writes 0x5A to addr 3 (E) → one wr strobe at addr 3 with data 0x5A; rsp 2 cycles after accept. Then req0 reads addr 3 → rsp_data=0x005A, 3 cycles after accept.
- Pair write then read: req1 writes 0xBEEF to pair addr 4 (HL) → H=0xBE written at addr 4, then L=0xEF at addr 5, on consecutive cycles. A pair read of addr 5 returns 0xBEEF, rsp_id=1, 4 cycles after accept.
- Contention: both requesters hold valid continuously after reset → grants alternate 0,1,0,1. With REGFILE_CTRL_FIXED_PRIO_EN defined → always 0.
- Illegal requests: pair access to addr 6, and byte read of addr 6 → rsp_err=1, data 0, no strobes, rsp 1 cycle after accept.
- Reset mid-pair-write: assert i_reset low during BYTE1 of a 0x1234 write to BC → outputs go to 0 immediately, no rsp; B reads 0x12 and C keeps its old value.
- Back-to-back: a second request is already valid during RSP → accepted in the very next IDLE cycle; no strobe overlaps between transactions.
